// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin HC-SR04 scheduler: fires one sensor per slot, times its echo, stores mm distance + flags.
// Latency: trig rises 2 cycles after enable is sampled; upd_stb rises 3 cycles after echo_rx falls.
// Backpressure: none; each slot result overwrites that sensor's entry and is announced by a 1-cycle upd_stb.
module ultrasonic_scan_scheduler #(
    parameter int N_SENSORS      = 4,
    parameter int TRIG_CYCLES    = 500,
    parameter int DIV_CYCLES     = 294,
    parameter int TIMEOUT_CYCLES = 1_900_000,
    parameter int GUARD_CYCLES   = 600_000,
    parameter int OBST_MM        = 70
) (
    input  logic                      clk_50M,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_SENSORS-1:0]      echo_rx,
    output logic [N_SENSORS-1:0]      trig,
    output logic [16*N_SENSORS-1:0]   distance_all,
    output logic [N_SENSORS-1:0]      valid,
    output logic [N_SENSORS-1:0]      op,
    output logic [N_SENSORS-1:0]      timeout,
    output logic                      upd_stb,
    output logic [2:0]                upd_id,
    output logic                      busy
);

    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_ECHO, S_MEASURE, S_GUARD} state_t;

    state_t                 state, state_nxt;
    logic [N_SENSORS-1:0]   echo_s1, echo_s2, echo_old;
    logic [31:0]            cnt;      // TRIG / GUARD phase length
    logic [31:0]            tcnt;     // time since WAIT_ECHO entry
    logic [31:0]            sub;      // cycles within the current millimetre
    logic [15:0]            mm;
    logic [2:0]             sel;
    logic [15:0]            dist_q [N_SENSORS];

    logic                   echo_cur, echo_prv, rise, fall, tmo;
    logic                   trig_done, guard_done;
    logic [15:0]            mm_final;
    logic [N_SENSORS-1:0]   trig_nxt;
    logic                   wr_en, wr_to;
    logic [15:0]            wr_val;

    // Pick the synchronized echo of the selected sensor; other sensors are ignored.
    always_comb begin
        echo_cur = 1'b0;
        echo_prv = 1'b0;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (sel == 3'(i)) begin
                echo_cur = echo_s2[i];
                echo_prv = echo_old[i];
            end
        end
    end

    assign rise       = echo_cur & ~echo_prv;
    assign fall       = ~echo_cur & echo_prv;
    assign tmo        = (tcnt == 32'(TIMEOUT_CYCLES - 1));
    assign trig_done  = (cnt == 32'(TRIG_CYCLES - 1));
    assign guard_done = (cnt == 32'(GUARD_CYCLES - 1));
    assign busy       = (state != S_IDLE);

    // The rising-edge cycle is not counted by sub, so a sub sitting at DIV-1
    // on the falling edge completes one more millimetre.
    assign mm_final = (sub == 32'(DIV_CYCLES - 1) && mm != 16'hFFFE) ? mm + 16'd1 : mm;

    // State register.
    always_ff @(posedge clk_50M) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; timeout wins over a coincident falling edge.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (enable) state_nxt = S_TRIG;
            S_TRIG:      if (trig_done) state_nxt = S_WAIT_ECHO;
            S_WAIT_ECHO: if (tmo) state_nxt = S_GUARD;
                         else if (rise) state_nxt = S_MEASURE;
            S_MEASURE:   if (tmo || fall) state_nxt = S_GUARD;
            S_GUARD:     if (guard_done) state_nxt = enable ? S_TRIG : S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Output decode: trigger pattern and slot-result write.
    always_comb begin
        trig_nxt = '0;
        wr_en    = 1'b0;
        wr_to    = 1'b0;
        wr_val   = mm_final;
        if (state == S_TRIG) begin
            for (int i = 0; i < N_SENSORS; i++) trig_nxt[i] = (sel == 3'(i));
        end
        if ((state == S_WAIT_ECHO && tmo) || (state == S_MEASURE && (tmo || fall))) begin
            wr_en  = 1'b1;
            wr_to  = tmo;
            wr_val = tmo ? 16'hFFFF : mm_final;
        end
    end

    // Echo synchronizers, phase counters, width counters and sensor selection.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            echo_s1  <= '0;
            echo_s2  <= '0;
            echo_old <= '0;
            cnt      <= '0;
            tcnt     <= '0;
            sub      <= '0;
            mm       <= '0;
            sel      <= '0;
        end else begin
            echo_s1  <= echo_rx;
            echo_s2  <= echo_s1;
            echo_old <= echo_s2;
            cnt      <= (state_nxt != state) ? 32'd0 : cnt + 32'd1;
            if (state == S_TRIG)
                tcnt <= '0;
            else if (state == S_WAIT_ECHO || state == S_MEASURE)
                tcnt <= tcnt + 32'd1;
            if (state == S_WAIT_ECHO && rise) begin
                sub <= '0;
                mm  <= '0;
            end else if (state == S_MEASURE && !fall) begin
                if (sub == 32'(DIV_CYCLES - 1)) begin
                    sub <= '0;
                    if (mm != 16'hFFFE) mm <= mm + 16'd1;
                end else begin
                    sub <= sub + 32'd1;
                end
            end
            if (state == S_GUARD && guard_done)
                sel <= (sel == 3'(N_SENSORS - 1)) ? 3'd0 : sel + 3'd1;
        end
    end

    // Registered trigger and per-sensor result storage.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            trig    <= '0;
            valid   <= '0;
            timeout <= '0;
            upd_stb <= 1'b0;
            upd_id  <= '0;
            for (int i = 0; i < N_SENSORS; i++) dist_q[i] <= '0;
        end else begin
            trig    <= trig_nxt;
            upd_stb <= wr_en;
            if (wr_en) upd_id <= sel;
            for (int i = 0; i < N_SENSORS; i++) begin
                if (wr_en && sel == 3'(i)) begin
                    dist_q[i]  <= wr_val;
                    valid[i]   <= 1'b1;
                    timeout[i] <= wr_to;
                end
            end
        end
    end

    // Flatten distances and derive obstacle flags from the stored results.
    always_comb begin
        distance_all = '0;
        op           = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            distance_all[16*i +: 16] = dist_q[i];
            op[i] = valid[i] & ~timeout[i] & (dist_q[i] <= 16'(OBST_MM));
        end
    end

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Bench for ultrasonic_scan_scheduler with shortened timing parameters.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_ultrasonic_scan_scheduler;

    localparam int N     = 4;
    localparam int TRIG  = 4;
    localparam int DIV   = 5;
    localparam int TO    = 200;
    localparam int GUARD = 6;
    localparam int OBST  = 7;

    logic              clk_50M = 1'b0;
    logic              reset;
    logic              enable;
    logic [N-1:0]      echo_rx;
    logic [N-1:0]      trig;
    logic [16*N-1:0]   distance_all;
    logic [N-1:0]      valid, op, timeout;
    logic              upd_stb;
    logic [2:0]        upd_id;
    logic              busy;

    ultrasonic_scan_scheduler #(
        .N_SENSORS(N), .TRIG_CYCLES(TRIG), .DIV_CYCLES(DIV),
        .TIMEOUT_CYCLES(TO), .GUARD_CYCLES(GUARD), .OBST_MM(OBST)
    ) dut (
        .clk_50M(clk_50M), .reset(reset), .enable(enable), .echo_rx(echo_rx),
        .trig(trig), .distance_all(distance_all), .valid(valid), .op(op),
        .timeout(timeout), .upd_stb(upd_stb), .upd_id(upd_id), .busy(busy)
    );

    always #5 clk_50M = ~clk_50M;

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    logic [15:0] m_dist [N];
    logic [N-1:0] m_valid, m_to;

    typedef struct {
        int          d;
        int          w;
        logic [15:0] ed;
        bit          et;
        bit          eop;
    } vec_t;
    vec_t tv [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no event within bound, expected one", name);
    endtask

    // Expected outcome of one slot from echo delay d (cycles after trig is seen low)
    // and synced width w. The echo is seen by the scheduler 4 cycles after it is
    // driven (wait starts one cycle before trig drops, two synchronizer stages,
    // one edge-detect stage), and the timeout window counts from wait start.
    function automatic void ref_slot(input int d, input int w,
                                     output logic [15:0] ed, output bit et);
        et = (w == 0) || (d + w + 4 >= TO);
        if (et)                 ed = 16'hFFFF;
        else if (w / DIV > 65534) ed = 16'hFFFE;
        else                    ed = 16'(w / DIV);
    endfunction

    task automatic check_all(input string tag);
        logic [63:0] ev;
        logic [N-1:0] eop;
        ev  = '0;
        eop = '0;
        for (int i = 0; i < N; i++) begin
            ev[16*i +: 16] = m_dist[i];
            eop[i] = m_valid[i] && !m_to[i] && (m_dist[i] <= 16'(OBST));
        end
        chk({tag, "_dist"},    64'(distance_all), ev);
        chk({tag, "_valid"},   64'(valid),   64'(m_valid));
        chk({tag, "_timeout"}, 64'(timeout), 64'(m_to));
        chk({tag, "_op"},      64'(op),      64'(eop));
    endtask

    // Run one slot on sensor s: optional early echo (pre), a disturbing pulse on
    // another sensor (other >= 0), optional enable drop during the measurement.
    task automatic run_slot(input int s, input int d, input int w, input bit pre,
                            input int other, input bit drop_en,
                            input logic [15:0] ed, input bit et);
        int  n;
        int  hi;
        int  lat;
        bit  got;
        n = 0;
        while (trig == '0 && n < GUARD + 40) begin
            @(negedge clk_50M);
            n++;
        end
        if (trig == '0) begin
            fail_bound("trig_start");
            return;
        end
        chk("trig_onehot", 64'(trig), 64'(1) << s);
        hi = 0;
        while (trig != '0 && hi < TRIG * 4) begin
            if (pre && hi == 0) echo_rx[s] = 1'b1;
            @(negedge clk_50M);
            hi++;
        end
        chk("trig_width", 64'(hi), 64'(TRIG));
        got = 1'b0;
        lat = 0;
        for (int c = 0; c < TO + 10 && !got; c++) begin
            echo_rx[s] = (pre && c < 3) || (w > 0 && c >= d && c < d + w);
            if (other >= 0) echo_rx[other] = (c >= 1 && c < 9);
            if (drop_en && c == d + 2) enable = 1'b0;
            @(negedge clk_50M);
            if (upd_stb) begin
                got = 1'b1;
                lat = c;
            end
        end
        echo_rx = '0;
        if (!got) begin
            fail_bound("upd_stb_wait");
            return;
        end
        // Result appears 3 cycles after the echo is driven low.
        if (!et) chk("upd_latency", 64'(lat), 64'(d + w + 2));
        m_dist[s]  = ed;
        m_valid[s] = 1'b1;
        m_to[s]    = et;
        chk("upd_id", 64'(upd_id), 64'(s));
        chk("busy_slot", 64'(busy), 64'(1));
        check_all("slot");
        @(negedge clk_50M);
        chk("upd_stb_pulse", 64'(upd_stb), 64'(0));
        cur = (s + 1) % N;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_trig"},    64'(trig),         64'(0));
        chk({tag, "_dist"},    64'(distance_all), 64'(0));
        chk({tag, "_valid"},   64'(valid),        64'(0));
        chk({tag, "_op"},      64'(op),           64'(0));
        chk({tag, "_timeout"}, 64'(timeout),      64'(0));
        chk({tag, "_upd_stb"}, 64'(upd_stb),      64'(0));
        chk({tag, "_upd_id"},  64'(upd_id),       64'(0));
        chk({tag, "_busy"},    64'(busy),         64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ed;
        bit          et;
        int          d;
        int          w;
        int          n;

        // d, w, expected distance, expected timeout, expected obstacle
        tv[0] = '{3,   50,  16'd10,   1'b0, 1'b0};
        tv[1] = '{2,   0,   16'hFFFF, 1'b1, 1'b0};  // echo never rises
        tv[2] = '{1,   35,  16'd7,    1'b0, 1'b1};  // exactly at threshold
        tv[3] = '{5,   4,   16'd0,    1'b0, 1'b1};  // DIV-1 cycles -> 0 mm
        tv[4] = '{0,   5,   16'd1,    1'b0, 1'b1};  // DIV cycles -> 1 mm
        tv[5] = '{4,   40,  16'd8,    1'b0, 1'b0};  // one past threshold
        tv[6] = '{10,  39,  16'd7,    1'b0, 1'b1};
        tv[7] = '{20,  176, 16'hFFFF, 1'b1, 1'b0};  // fall coincides with timeout
        tv[8] = '{20,  175, 16'd35,   1'b0, 1'b0};  // fall one cycle before timeout
        tv[9] = '{196, 1,   16'hFFFF, 1'b1, 1'b0};  // rise too late

        for (int i = 0; i < N; i++) m_dist[i] = '0;
        m_valid = '0;
        m_to    = '0;

        reset   = 1'b1;
        enable  = 1'b0;
        echo_rx = '0;
        repeat (3) @(negedge clk_50M);
        check_reset_vals("reset");

        reset  = 1'b0;
        enable = 1'b1;
        @(negedge clk_50M);
        chk("start_trig_c1", 64'(trig), 64'(0));
        chk("start_busy_c1", 64'(busy), 64'(1));
        @(negedge clk_50M);
        chk("start_trig_c2", 64'(trig), 64'(1));

        for (int i = 0; i < 10; i++) begin
            n = cur;
            run_slot(cur, tv[i].d, tv[i].w, 1'b0, -1, 1'b0, tv[i].ed, tv[i].et);
            chk("tbl_op", 64'(op[n]), 64'(tv[i].eop));
            chk("tbl_dist", 64'(distance_all[16*n +: 16]), 64'(tv[i].ed));
        end

        for (int i = 0; i < 16; i++) begin
            d = $urandom_range(0, 30);
            w = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 190);
            ref_slot(d, w, ed, et);
            run_slot(cur, d, w, 1'b0, -1, 1'b0, ed, et);
        end

        // Pulse on a non-selected sensor must be ignored.
        ref_slot(12, 23, ed, et);
        run_slot(cur, 12, 23, 1'b0, (cur + 3) % N, 1'b0, ed, et);

        // Echo already high when trig ends: only the later fresh pulse counts.
        ref_slot(8, 17, ed, et);
        run_slot(cur, 8, 17, 1'b1, -1, 1'b0, ed, et);

        while (cur != 1) begin
            ref_slot(2, 12, ed, et);
            run_slot(cur, 2, 12, 1'b0, -1, 1'b0, ed, et);
        end

        // Enable dropped while sensor 1 measures: slot completes, then idle.
        ref_slot(3, 30, ed, et);
        run_slot(1, 3, 30, 1'b0, -1, 1'b1, ed, et);
        n = 0;
        while (busy && n < GUARD + 20) begin
            @(negedge clk_50M);
            n++;
        end
        chk("idle_busy", 64'(busy), 64'(0));
        repeat (10) @(negedge clk_50M);
        chk("idle_trig_hold", 64'(trig), 64'(0));
        chk("idle_busy_hold", 64'(busy), 64'(0));
        enable = 1'b1;
        ref_slot(1, 21, ed, et);
        run_slot(2, 1, 21, 1'b0, -1, 1'b0, ed, et);

        // Reset while a trigger pulse is high.
        n = 0;
        while (trig == '0 && n < GUARD + 40) begin
            @(negedge clk_50M);
            n++;
        end
        if (trig == '0) fail_bound("trig_before_reset");
        @(negedge clk_50M);
        reset = 1'b1;
        @(negedge clk_50M);
        check_reset_vals("midreset");
        @(negedge clk_50M);
        reset = 1'b0;
        for (int i = 0; i < N; i++) m_dist[i] = '0;
        m_valid = '0;
        m_to    = '0;
        cur     = 0;
        run_slot(0, 3, 20, 1'b0, -1, 1'b0, 16'd4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
